instr_aligner: RTL and testbench
================================

INSTR_ALIGNER -- requirements
Module: instr_aligner

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning width of all PC/address ports.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port flush_i, input, 1, discard all buffered state and restart at flush_pc_i.
REQ-005 SHALL have port flush_pc_i, input, ADDR_WIDTH, restart PC, halfword aligned; bit 0 is ignored.
REQ-006 SHALL have port fetch_valid_i, input, 1, fetch_rdata_i/fetch_addr_i hold a valid word.
REQ-007 SHALL have port fetch_ready_o, output, 1, the aligner consumes the current fetch word this cycle.
REQ-008 SHALL have port fetch_rdata_i, input, 32, fetched instruction word, little-endian halfwords.
REQ-009 SHALL have port fetch_addr_i, input, ADDR_WIDTH, word-aligned address of fetch_rdata_i.
REQ-010 SHALL have port instr_valid_o, output, 1, instr_o/instr_pc_o/instr_compressed_o are valid.
REQ-011 SHALL have port instr_ready_i, input, 1, the decode stage accepts the instruction.
REQ-012 SHALL have port instr_o, output, 32, aligned instruction; compressed instructions occupy [15:0] with [31:16]=0.
REQ-013 SHALL have port instr_pc_o, output, ADDR_WIDTH, PC of instr_o.
REQ-014 SHALL have port instr_compressed_o, output, 1, instr_o is a 16-bit instruction (bits[1:0]!=2'b11).

Function
REQ-015 SHALL hold state: 3-state FSM {ALIGNED, HALF, SKIP}, a 16-bit halfword buffer buf, and an ADDR_WIDTH buf_pc; lo=fetch_rdata_i[15:0], hi=fetch_rdata_i[31:16].
REQ-016 SHALL generate outputs combinationally from state and fetch inputs (zero-latency pass-through); a fetch handshake is fetch_valid_i&fetch_ready_o, an instr handshake is instr_valid_o&instr_ready_i.
REQ-017 ALIGNED, lo compressed: instr_valid_o=fetch_valid_i, instr_o={16'h0,lo}, pc=fetch_addr_i, fetch_ready_o=instr_ready_i; on handshake buf<=hi, buf_pc<=fetch_addr_i+2, go to HALF.
REQ-018 ALIGNED, lo uncompressed: instr_valid_o=fetch_valid_i, instr_o=fetch_rdata_i, pc=fetch_addr_i, fetch_ready_o=instr_ready_i; stay in ALIGNED.
REQ-019 HALF, buf compressed: instr_valid_o=1 independent of fetch_valid_i, instr_o={16'h0,buf}, pc=buf_pc, fetch_ready_o=0; on handshake go to ALIGNED.
REQ-020 HALF, buf uncompressed: instr_valid_o=fetch_valid_i, instr_o={lo,buf}, pc=buf_pc, compressed=0, fetch_ready_o=instr_ready_i; on handshake buf<=hi, buf_pc<=buf_pc+4, stay in HALF.
REQ-021 SKIP: instr_valid_o=0, fetch_ready_o=1; on fetch handshake discard lo, buf<=hi, buf_pc<=fetch_addr_i+2, go to HALF (one-bubble cost).
REQ-022 flush_i SHALL take priority over all handshakes: force instr_valid_o=0 and fetch_ready_o=1 (the stale word is dropped); next state is SKIP if flush_pc_i[1]=1, else ALIGNED; buf is invalidated.
REQ-023 SHALL use only fetch_addr_i as the PC source in ALIGNED and SKIP; the fetch unit guarantees that the first post-flush word is at {flush_pc_i[ADDR_WIDTH-1:2],2'b00}.
REQ-024 SHALL keep outputs stable while instr_valid_o=1 and instr_ready_i=0, given stable fetch inputs; state changes only on handshake, flush or reset.
REQ-025 SHALL wrap address arithmetic (+2, +4) modulo 2^ADDR_WIDTH without error.

Reset
REQ-026 While rst_i=1, the block SHALL force instr_valid_o=0 and fetch_ready_o=0; on the next edge state=ALIGNED, buf=16'h0, buf_pc=0; rst_i SHALL take priority over flush_i.
REQ-027 Reset asserted mid-instruction SHALL discard buf with no output handshake.

Verification
REQ-028 Reset, then word 0x00B50533 @0x100, ready=1 -> instr 0x00B50533, pc 0x100, compressed=0, fetch consumed same cycle.
REQ-029 Word 0x45014501 @0x200 -> cycle1 instr 0x00004501 pc 0x200 with fetch consumed; cycle2 instr 0x00004501 pc 0x202, fetch_ready_o=0; then ALIGNED.
REQ-030 Words 0x05334501 @0x300, 0x000000B5 @0x304 -> 0x4501 pc 0x300, then 0x00B50533 pc 0x302 compressed=0, state HALF with buf=0x0000.
REQ-031 flush_i with flush_pc_i=0x402, then word 0x12344501 @0x400 -> bubble (valid=0, lo dropped); next cycle HALF with buf=0x1234 and buf_pc=0x402.
REQ-032 instr_ready_i=0 for 3 cycles with valid output -> outputs and state unchanged, fetch_ready_o=0; flush_i mid-stall -> valid=0 on the next cycle.

Source files
------------

// File: rtl/instr_aligner.sv
// Instruction aligner: turns a stream of 32-bit little-endian fetch words into
// whole 16/32-bit instructions, with combinational pass-through and a halfword buffer.
module instr_aligner #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] flush_pc_i,
  input  logic                  fetch_valid_i,
  output logic                  fetch_ready_o,
  input  logic [31:0]           fetch_rdata_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic                  instr_compressed_o
);

  typedef enum logic [1:0] {
    ST_ALIGNED = 2'd0,
    ST_HALF    = 2'd1,
    ST_SKIP    = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             buf_q, buf_d;
  logic [ADDR_WIDTH-1:0]   buf_pc_q, buf_pc_d;

  logic [15:0] lo, hi;
  logic        lo_compr, buf_compr;
  logic        instr_valid, fetch_ready;
  logic        instr_hs, fetch_hs;

  assign lo        = fetch_rdata_i[15:0];
  assign hi        = fetch_rdata_i[31:16];
  assign lo_compr  = (lo[1:0] != 2'b11);
  assign buf_compr = (buf_q[1:0] != 2'b11);

  // Output decode. Everything is a function of current state and the live
  // fetch word so a word can be consumed in the same cycle it arrives.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    instr_valid        = 1'b0;
    fetch_ready        = 1'b0;
    instr_o            = 32'h0;
    instr_pc_o         = fetch_addr_i;
    instr_compressed_o = 1'b0;

    unique case (state_q)
      ST_ALIGNED: begin
        instr_valid = fetch_valid_i;
        fetch_ready = instr_ready_i;
        instr_pc_o  = fetch_addr_i;
        if (lo_compr) begin
          instr_o            = {16'h0, lo};
          instr_compressed_o = 1'b1;
        end else begin
          instr_o = fetch_rdata_i;
        end
      end
      ST_HALF: begin
        instr_pc_o = buf_pc_q;
        if (buf_compr) begin
          // The buffered halfword is a whole instruction; the fetch word waits.
          instr_valid        = 1'b1;
          instr_o            = {16'h0, buf_q};
          instr_compressed_o = 1'b1;
        end else begin
          instr_valid = fetch_valid_i;
          fetch_ready = instr_ready_i;
          instr_o     = {lo, buf_q};
        end
      end
      ST_SKIP: begin
        fetch_ready = 1'b1;
      end
      default: begin
        instr_valid = 1'b0;
        fetch_ready = 1'b0;
      end
    endcase

    if (flush_i) begin
      instr_valid = 1'b0;
      fetch_ready = 1'b1;
    end
    if (rst_i) begin
      instr_valid = 1'b0;
      fetch_ready = 1'b0;
    end
  end

  assign instr_valid_o = instr_valid;
  assign fetch_ready_o = fetch_ready;
  assign instr_hs      = instr_valid & instr_ready_i;
  assign fetch_hs      = fetch_valid_i & fetch_ready;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    buf_pc_d = buf_pc_q;

    if (flush_i) begin
      // A restart PC in the upper halfword means the low half of the first word is dropped.
      state_d  = flush_pc_i[1] ? ST_SKIP : ST_ALIGNED;
      buf_d    = 16'h0;
      buf_pc_d = flush_pc_i & ~ADDR_WIDTH'(1);
    end else begin
      unique case (state_q)
        ST_ALIGNED: begin
          if (instr_hs && lo_compr) begin
            state_d  = ST_HALF;
            buf_d    = hi;
            buf_pc_d = fetch_addr_i + ADDR_WIDTH'(2);
          end
        end
        ST_HALF: begin
          if (instr_hs) begin
            if (buf_compr) begin
              state_d = ST_ALIGNED;
            end else begin
              buf_d    = hi;
              buf_pc_d = buf_pc_q + ADDR_WIDTH'(4);
            end
          end
        end
        ST_SKIP: begin
          if (fetch_hs) begin
            state_d  = ST_HALF;
            buf_d    = hi;
            buf_pc_d = fetch_addr_i + ADDR_WIDTH'(2);
          end
        end
        default: state_d = ST_ALIGNED;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_ALIGNED;
      buf_q    <= 16'h0;
      buf_pc_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q  <= state_d;
      buf_q    <= buf_d;
      buf_pc_q <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_aligner.sv
// Directed bench for instr_aligner: a cycle-by-cycle vector table plus hand
// sequences for stalls, flush-during-stall and address wrap.
module tb_instr_aligner;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, fetch_valid_i, instr_ready_i;
  logic [31:0] flush_pc_i, fetch_rdata_i, fetch_addr_i;
  logic        fetch_ready_o, instr_valid_o, instr_compressed_o;
  logic [31:0] instr_o, instr_pc_o;

  int n_pass  = 0;
  int n_total = 0;

  instr_aligner #(.ADDR_WIDTH(32)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .flush_i            (flush_i),
    .flush_pc_i         (flush_pc_i),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_ready_o      (fetch_ready_o),
    .fetch_rdata_i      (fetch_rdata_i),
    .fetch_addr_i       (fetch_addr_i),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .instr_o            (instr_o),
    .instr_pc_o         (instr_pc_o),
    .instr_compressed_o (instr_compressed_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [31:0] fpc;
    logic        fv;
    logic [31:0] rd;
    logic [31:0] ad;
    logic        rdy;
    logic        ev;
    logic        er;
    logic        chk;
    logic [31:0] ei;
    logic [31:0] ep;
    logic        ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic flush, input logic [31:0] fpc,
                              input logic fv, input logic [31:0] rd, input logic [31:0] ad,
                              input logic rdy, input logic ev, input logic er, input logic chk,
                              input logic [31:0] ei, input logic [31:0] ep, input logic ec);
    vec_t v;
    v.rst = rst; v.flush = flush; v.fpc = fpc; v.fv = fv; v.rd = rd; v.ad = ad;
    v.rdy = rdy; v.ev = ev; v.er = er; v.chk = chk; v.ei = ei; v.ep = ep; v.ec = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle's inputs after the falling edge, compare once settled.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk_i);
    rst_i         = v.rst;
    flush_i       = v.flush;
    flush_pc_i    = v.fpc;
    fetch_valid_i = v.fv;
    fetch_rdata_i = v.rd;
    fetch_addr_i  = v.ad;
    instr_ready_i = v.rdy;
    #1;
    check({tag, ".valid"}, 32'(instr_valid_o), 32'(v.ev));
    check({tag, ".fready"}, 32'(fetch_ready_o), 32'(v.er));
    if (v.chk) begin
      check({tag, ".instr"}, instr_o, v.ei);
      check({tag, ".pc"}, instr_pc_o, v.ep);
      check({tag, ".compr"}, 32'(instr_compressed_o), 32'(v.ec));
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; flush_pc_i = '0; fetch_valid_i = 1'b0;
    fetch_rdata_i = '0; fetch_addr_i = '0; instr_ready_i = 1'b0;

    //                rst flush fpc           fv rd            ad            rdy ev er chk ei            ep            ec
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,        32'h0,        1,  0, 0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 1, 32'h402,        1, 32'h45014501, 32'h100,      1,  0, 0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,        32'h0,        1,  0, 1, 0, 32'h0,        32'h0,        0));
    // full-width instruction passes straight through
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'h00B50533, 32'h100,      1,  1, 1, 1, 32'h00B50533, 32'h100,      0));
    // two compressed in one word
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'h45014501, 32'h200,      1,  1, 1, 1, 32'h00004501, 32'h200,      1));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,        32'h0,        1,  1, 0, 1, 32'h00004501, 32'h202,      1));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,        32'h0,        1,  0, 1, 0, 32'h0,        32'h0,        0));
    // compressed then a 32-bit instruction straddling two words
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'h05334501, 32'h300,      1,  1, 1, 1, 32'h00004501, 32'h300,      1));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,        32'h0,        1,  0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'h000000B5, 32'h304,      1,  1, 1, 1, 32'h00B50533, 32'h302,      0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'hDEADBEEF, 32'h308,      1,  1, 0, 1, 32'h00000000, 32'h306,      1));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'hDEADBEEF, 32'h308,      1,  1, 1, 1, 32'hDEADBEEF, 32'h308,      0));
    // flush into the upper halfword: one bubble, low half dropped
    vecs.push_back(mk(0, 1, 32'h402,        1, 32'h11111111, 32'h30C,      1,  0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,        32'h0,        1,  0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'h12344501, 32'h400,      1,  0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,        32'h0,        1,  1, 0, 1, 32'h00001234, 32'h402,      1));
    // address wrap on +2 and +4
    vecs.push_back(mk(0, 1, 32'hFFFFFFFF,   0, 32'h0,        32'h0,        1,  0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'h0533ABCD, 32'hFFFFFFFC, 1,  0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'h000000B5, 32'h0,        1,  1, 1, 1, 32'h00B50533, 32'hFFFFFFFE, 0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,        32'h0,        1,  1, 0, 1, 32'h00000000, 32'h2,        1));
    // flush to an even PC, then a one-cycle decode stall in ALIGNED
    vecs.push_back(mk(0, 1, 32'h500,        0, 32'h0,        32'h0,        1,  0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'h00000001, 32'h500,      0,  1, 0, 1, 32'h00000001, 32'h500,      1));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'h00000001, 32'h500,      1,  1, 1, 1, 32'h00000001, 32'h500,      1));
    // reset while a halfword is buffered drops it
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,        32'h0,        1,  0, 0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,        32'h0,        1,  0, 1, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'h00B50533, 32'h504,      1,  1, 1, 1, 32'h00B50533, 32'h504,      0));

    foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));

    // Stall in ALIGNED for three cycles, then accept.
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, 32'h0, 1, 32'h45014501, 32'h600, 0, 1, 0, 1, 32'h00004501, 32'h600, 1),
           $sformatf("stallA%0d", i));
    step(mk(0, 0, 32'h0, 1, 32'h45014501, 32'h600, 1, 1, 1, 1, 32'h00004501, 32'h600, 1), "acceptA");

    // Stall in HALF (buffered compressed) for three cycles.
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, 32'h0, 1, 32'h77777777, 32'h604, 0, 1, 0, 1, 32'h00004501, 32'h602, 1),
           $sformatf("stallH%0d", i));

    // Flush mid-stall: output dies immediately and stays dead next cycle.
    step(mk(0, 1, 32'h700, 1, 32'h77777777, 32'h604, 0, 0, 1, 0, 32'h0, 32'h0, 0), "flushStall");
    step(mk(0, 0, 32'h0,   0, 32'h0,        32'h0,   0, 0, 0, 0, 32'h0, 32'h0, 0), "postFlush");
    step(mk(0, 0, 32'h0,   1, 32'h00B50533, 32'h700, 1, 1, 1, 1, 32'h00B50533, 32'h700, 0), "restart");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
